mips_multicycle_ctrl: RTL and testbench

- Main control FSM for the multicycle MIPS core.
- Sequences the shared instruction/data memory, instruction register, register file, ALU and PC mux each cycle, based on opcode/funct of the latched instruction and the ALU zero flag.
- Its memwrite and iord outputs drive the memwrite/dataadr selection seen on the processor memory interface.
- Moore FSM plus a combinational ALU decoder and PC-enable logic.

---
 rtl/mips_multicycle_ctrl_if.sv | 38 +++
 rtl/mips_multicycle_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_ctrl_if.sv
// Control/datapath bundle for the multicycle MIPS controller.
// master = controller side, slave = datapath side.
interface mips_multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic       illegal_op;

  modport master (
    input  op, funct, zero,
    output pcen, memwrite, irwrite,
    output regwrite, iord, memtoreg,
    output regdst, alusrca, alusrcb,
    output pcsrc, alucontrol, state,
    output illegal_op
  );

  modport slave (
    output op, funct, zero,
    input  pcen, memwrite, irwrite,
    input  regwrite, iord, memtoreg,
    input  regdst, alusrca, alusrcb,
    input  pcsrc, alucontrol, state,
    input  illegal_op
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: Moore state
// sequencer, ALU decoder and PC-enable logic.
module mips_multicycle_ctrl (
  input  logic                  clk,
  input  logic                  reset,
  mips_multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     state_q;
  state_t     state_d;

  logic       pcwrite;
  logic       branch;
  logic [1:0] aluop;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       illegal;
  logic [2:0] alucontrol;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = FETCH;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    aluop    = 2'b00;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    illegal  = 1'b0;
    unique case (state_q)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = 1'b1;
        pcwrite = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (bus.op)
          OP_LW,
          OP_SW:    state_d = MEMADR;
          OP_RTYPE: state_d = EXECUTE;
          OP_BEQ:   state_d = BRANCH;
          OP_ADDI:  state_d = ADDIEX;
          OP_J:     state_d = JUMP;
          default: begin
            state_d = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        // Only lw/sw reach here; anything else aborts to FETCH.
        if (bus.op == OP_LW)      state_d = MEMRD;
        else if (bus.op == OP_SW) state_d = MEMWR;
        else                      state_d = FETCH;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        regwrite = 1'b1;
      end
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // funct only matters for R-type execution (aluop 10).
  always_comb begin
    alucontrol = 3'b010;
    unique case (aluop)
      2'b00: alucontrol = 3'b010;
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (bus.funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      2'b11: alucontrol = 3'b010;
      default: alucontrol = 3'b010;
    endcase
  end

  assign bus.pcen       = pcwrite | (branch & bus.zero);
  assign bus.memwrite   = memwrite;
  assign bus.irwrite    = irwrite;
  assign bus.regwrite   = regwrite;
  assign bus.iord       = iord;
  assign bus.memtoreg   = memtoreg;
  assign bus.regdst     = regdst;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.pcsrc      = pcsrc;
  assign bus.alucontrol = alucontrol;
  assign bus.state      = state_q;
  assign bus.illegal_op = illegal;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl against an
// instruction-level reference model.
module tb_mips_multicycle_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic legal(input logic [5:0] o);
    return o inside {6'b000000, 6'b100011, 6'b101011,
                     6'b000100, 6'b001000, 6'b000010};
  endfunction

  function automatic logic [2:0] rfunc(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic [15:0] obs();
    return {bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite,
            bus.iord, bus.memtoreg, bus.regdst, bus.alusrca,
            bus.alusrcb, bus.pcsrc, bus.alucontrol,
            bus.illegal_op};
  endfunction

  // Expected control word for a given step of an instruction.
  function automatic logic [15:0] expv(input int s,
                                       input logic [5:0] o,
                                       input logic [5:0] f,
                                       input logic z);
    logic pe, mw, irw, rw, io, m2r, rd, sa, ill;
    logic [1:0] sb, ps;
    logic [2:0] ac;
    {pe, mw, irw, rw, io, m2r, rd, sa, ill} = '0;
    sb = 2'b00;
    ps = 2'b00;
    ac = 3'b010;
    case (s)
      0:  begin sb = 2'b01; irw = 1; pe = 1; end
      1:  begin sb = 2'b11; ill = !legal(o); end
      2:  begin sa = 1; sb = 2'b10; end
      3:  io = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin io = 1; mw = 1; end
      6:  begin sa = 1; ac = rfunc(f); end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; ps = 2'b01; ac = 3'b110; pe = z; end
      9:  begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    return {pe, mw, irw, rw, io, m2r, rd, sa, sb, ps, ac, ill};
  endfunction

  // zmode < 0: random zero flag; rst_at: step at which reset is raised.
  task automatic run_instr(input logic [5:0] o,
                           input logic [5:0] f,
                           input int zmode,
                           input int rst_at);
    int seq[$];
    seq = {0, 1};
    case (o)
      6'b100011: seq = {seq, 2, 3, 4};
      6'b101011: seq = {seq, 2, 5};
      6'b000000: seq = {seq, 6, 7};
      6'b000100: seq = {seq, 8};
      6'b001000: seq = {seq, 9, 10};
      6'b000010: seq = {seq, 11};
      default: ;
    endcase
    for (int k = 0; k < seq.size(); k++) begin
      int s;
      s = seq[k];
      @(negedge clk);
      bus.op    = (s == 1 || s == 2) ? o : 6'($urandom);
      bus.funct = (s == 6) ? f : 6'($urandom);
      bus.zero  = (zmode < 0) ? 1'($urandom) : 1'(zmode);
      reset     = (k == rst_at);
      #1;
      check($sformatf("state op=%h step%0d", o, k),
            32'(bus.state), 32'(s));
      check($sformatf("ctl op=%h st%0d", o, s),
            32'(obs()), 32'(expv(s, bus.op, bus.funct, bus.zero)));
      if (k == rst_at) break;
    end
  endtask

  initial begin
    logic [5:0] ops [6];
    logic [5:0] fns [5];
    logic [5:0] o;
    logic [5:0] f;
    ops = '{6'b000000, 6'b100011, 6'b101011,
            6'b000100, 6'b001000, 6'b000010};
    fns = '{6'b100000, 6'b100010, 6'b100100,
            6'b100101, 6'b101010};
    reset     = 1'b1;
    bus.op    = 6'b0;
    bus.funct = 6'b0;
    bus.zero  = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_state", 32'(bus.state), 32'd0);
      check("rst_memwrite", 32'(bus.memwrite), 32'd0);
      check("rst_regwrite", 32'(bus.regwrite), 32'd0);
    end

    run_instr(6'b100011, 6'h00, -1, -1);
    run_instr(6'b101011, 6'h00, -1, -1);
    run_instr(6'b000000, 6'b101010, -1, -1);
    run_instr(6'b000000, 6'b100100, -1, -1);
    run_instr(6'b000100, 6'h00, 1, -1);
    run_instr(6'b000100, 6'h00, 0, -1);
    run_instr(6'b000010, 6'h00, -1, -1);
    run_instr(6'b111111, 6'h00, -1, -1);
    run_instr(6'b100011, 6'h00, -1, 3);
    run_instr(6'b101011, 6'h00, -1, 2);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 6) == 0) begin
        do o = 6'($urandom); while (legal(o));
      end else begin
        o = ops[$urandom_range(0, 5)];
      end
      if ($urandom_range(0, 3) == 0) f = 6'($urandom);
      else f = fns[$urandom_range(0, 4)];
      run_instr(o, f, -1,
                ($urandom_range(0, 7) == 0) ?
                int'($urandom_range(0, 5)) : -1);
    end

    @(negedge clk);
    reset = 1'b0;
    #1;
    check("final_state", 32'(bus.state), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
